// File: rtl/onehot_encoder_pipe.sv
// Purpose: one-hot to binary index encoder (MSB-first: bit WIDTH-1 -> index 0) with a not-one-hot flag and saturating error count.
// Latency: 2 cycles (vector accepted at edge N gives out_valid=1 after edge N+1); 1 vector/cycle when out_ready=1.
// Backpressure: valid/ready on both sides; in_ready is combinational from out_ready, stages hold while the output is stalled.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   in_valid/in_ready/in_onehot        upstream handshake and select vector
//   out_valid/out_ready/out_idx/out_err downstream handshake, encoded index, not-one-hot flag
//   err_clr/err_count                  clear and value of the errored-transfer counter
module onehot_encoder_pipe #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_onehot,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_idx,
   output logic             out_err,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_count
);

   localparam int GW  = WIDTH / 4;          // bits per group
   localparam int LW  = IDX_W - 2;          // local index width
   localparam int LWS = (LW > 0) ? LW : 1;  // storage width, WIDTH=4 leaves no local bits

   typedef struct packed {
      logic           any;
      logic           multi;
      logic [LWS-1:0] loc;
   } grp_t;

   logic             s1_valid;
   grp_t             s1_grp [4];
   grp_t             grp_c  [4];
   logic [GW-1:0]    gb     [4];
   logic             s2_load;
   logic             s1_load;
   logic [1:0]       sel;
   logic [2:0]       nset;
   logic [IDX_W-1:0] idx_c;
   logic             err_c;

   assign s2_load  = !out_valid || out_ready;
   assign s1_load  = !s1_valid || s2_load;
   assign in_ready = s1_load;

   // Group 0 holds the most significant bits, so it carries the lowest indices.
   always_comb begin
      for (int g = 0; g < 4; g++) begin
         gb[g] = in_onehot[WIDTH-1-g*GW -: GW];
      end
   end

   // Within a group, local position p corresponds to bit GW-1-p; scanning down
   // leaves the lowest local index (most significant set bit) as the winner.
   always_comb begin
      for (int g = 0; g < 4; g++) begin
         grp_c[g].any   = |gb[g];
         grp_c[g].multi = |(gb[g] & (gb[g] - GW'(1)));
         grp_c[g].loc   = '0;
         for (int p = GW - 1; p >= 0; p--) begin
            if (gb[g][GW-1-p]) begin
               grp_c[g].loc = LWS'(p);
            end
         end
      end
   end

   // Combine: lowest-numbered set group wins; error if zero or several
   // groups are set, or the winning group itself is multi-hot.
   always_comb begin
      sel  = '0;
      nset = '0;
      for (int g = 3; g >= 0; g--) begin
         if (s1_grp[g].any) begin
            sel = 2'(g);
         end
         nset = nset + 3'(s1_grp[g].any);
      end
      idx_c = (IDX_W'(sel) << LW) | IDX_W'(s1_grp[sel].loc);
      err_c = (nset != 3'd1) || s1_grp[sel].multi;
   end

   // Stage 1: per-group summaries; data only moves when a real vector arrives.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         for (int g = 0; g < 4; g++) begin
            s1_grp[g] <= '0;
         end
      end else if (s1_load) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            for (int g = 0; g < 4; g++) begin
               s1_grp[g] <= grp_c[g];
            end
         end
      end
   end

   // Stage 2: output register; a bubble clears out_valid but keeps idx/err.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_err   <= 1'b0;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_idx <= idx_c;
            out_err <= err_c;
         end
      end
   end

   // Counts errored output transfers; clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || err_clr) begin
         err_count <= '0;
      end else if (out_valid && out_ready && out_err && (err_count != '1)) begin
         err_count <= err_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_onehot_encoder_pipe.sv
module tb_onehot_encoder_pipe;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [31:0] in_onehot;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [4:0]  out_idx, out_idx2;
   logic        out_err, out_err2;
   logic        err_clr;
   logic [7:0]  err_count;
   logic [1:0]  err_count2;

   always #5 clk = ~clk;

   onehot_encoder_pipe #(.WIDTH(32), .IDX_W(5), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_onehot(in_onehot), .out_valid(out_valid), .out_ready(out_ready),
      .out_idx(out_idx), .out_err(out_err), .err_clr(err_clr), .err_count(err_count)
   );

   // Same stimulus, narrow counter to exercise saturation.
   onehot_encoder_pipe #(.WIDTH(32), .IDX_W(5), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
      .in_onehot(in_onehot), .out_valid(out_valid2), .out_ready(out_ready),
      .out_idx(out_idx2), .out_err(out_err2), .err_clr(err_clr), .err_count(err_count2)
   );

   typedef struct packed {
      logic [4:0] idx;
      logic       err;
   } exp_t;

   exp_t        q[$];
   logic [31:0] pend[$];
   int          checks   = 0;
   int          failures = 0;
   int          m_cnt8   = 0;
   int          m_cnt2   = 0;
   int          n_out    = 0;
   logic        acc;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: index of the most significant set bit counted from the top.
   function automatic exp_t model(input logic [31:0] v);
      exp_t e;
      e.idx = '0;
      e.err = ($countones(v) != 1);
      for (int pos = 0; pos < 32; pos++) begin
         if (v[pos]) e.idx = 5'(31 - pos);
      end
      return e;
   endfunction

   function automatic logic [31:0] rnd_vec();
      logic [31:0] v;
      case ($urandom_range(0, 9))
         0:       v = 32'h0;
         1:       v = $urandom;
         2:       v = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
         default: v = 32'h1 << $urandom_range(0, 31);
      endcase
      return v;
   endfunction

   // One cycle: called at a negedge, applies inputs, scores the transfers of
   // the coming posedge, and returns at the following negedge.
   task automatic drive(input logic v, input logic [31:0] d, input logic ordy,
                        input logic clr, output logic accepted);
      logic otx;
      exp_t e;
      in_valid  = v;
      in_onehot = d;
      out_ready = ordy;
      err_clr   = clr;
      #1;
      accepted = v && in_ready && !reset;
      otx      = out_valid && out_ready && !reset;
      e        = '0;
      if (otx) begin
         n_out++;
         chk("out_present", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("out_idx", 64'(out_idx), 64'(e.idx));
            chk("out_err", 64'(out_err), 64'(e.err));
            chk("out_idx2", 64'(out_idx2), 64'(e.idx));
            chk("out_err2", 64'(out_err2), 64'(e.err));
         end
      end
      if (clr) begin
         m_cnt8 = 0;
         m_cnt2 = 0;
      end else if (otx && e.err) begin
         if (m_cnt8 < 255) m_cnt8++;
         if (m_cnt2 < 3) m_cnt2++;
      end
      if (accepted) q.push_back(model(d));
      @(posedge clk);
      @(negedge clk);
      if (reset) begin
         q.delete();
         m_cnt8 = 0;
         m_cnt2 = 0;
      end
      chk("err_count", 64'(err_count), 64'(m_cnt8));
      chk("err_count2", 64'(err_count2), 64'(m_cnt2));
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && q.size() != 0; i++) drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      int n0;
      reset = 1'b1; in_valid = 1'b0; in_onehot = '0; out_ready = 1'b0; err_clr = 1'b0;
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b0, 1'b0, acc);
      drive(1'b0, 32'h0, 1'b0, 1'b0, acc);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_idx", 64'(out_idx), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      reset = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      // Back-to-back stream, explicit latency and values.
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b0, acc);
      chk("lat_not_yet", 64'(out_valid), 64'd0);
      drive(1'b1, 32'h0000_0001, 1'b1, 1'b0, acc);
      chk("s_vld0", 64'(out_valid), 64'd1);
      chk("s_idx0", 64'(out_idx), 64'd0);
      drive(1'b1, 32'h0001_0000, 1'b1, 1'b0, acc);
      chk("s_idx31", 64'(out_idx), 64'd31);
      drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("s_idx15", 64'(out_idx), 64'd15);
      chk("s_err", 64'(out_err), 64'd0);
      drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("s_bubble", 64'(out_valid), 64'd0);
      chk("s_bubble_idx", 64'(out_idx), 64'd15);

      // Error cases.
      drive(1'b1, 32'h0000_0000, 1'b1, 1'b0, acc);
      drive(1'b1, 32'h0000_0003, 1'b1, 1'b0, acc);
      chk("e_zero_idx", 64'(out_idx), 64'd0);
      chk("e_zero_err", 64'(out_err), 64'd1);
      drive(1'b1, 32'h8000_0001, 1'b1, 1'b0, acc);
      chk("e_multi_idx", 64'(out_idx), 64'd30);
      chk("e_multi_err", 64'(out_err), 64'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
      chk("e_cross_idx", 64'(out_idx), 64'd0);
      chk("e_cross_err", 64'(out_err), 64'd1);
      drain();
      chk("e_count3", 64'(err_count), 64'd3);
      drive(1'b0, 32'h0, 1'b1, 1'b1, acc);
      chk("e_clear", 64'(err_count), 64'd0);

      // Backpressure: 5 stalled cycles, 4 vectors offered.
      pend = '{32'h0000_0100, 32'h0400_0000, 32'h0000_0002, 32'h0020_0000};
      n0 = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, pend[0], 1'b0, 1'b0, acc);
         if (acc) begin
            void'(pend.pop_front());
            n0++;
         end
         if (i >= 2) chk("bp_stall_idx", 64'(out_idx), 64'd23);
      end
      chk("bp_accepted", 64'(n0), 64'd2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      n0 = n_out;
      for (int i = 0; i < 30 && (pend.size() != 0 || q.size() != 0); i++) begin
         if (pend.size() != 0) begin
            drive(1'b1, pend[0], 1'b1, 1'b0, acc);
            if (acc) void'(pend.pop_front());
         end else begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
         end
      end
      chk("bp_outputs", 64'(n_out - n0), 64'd4);
      chk("bp_empty", 64'(q.size()), 64'd0);

      // Saturation on the 2-bit counter, then clear vs errored transfer.
      for (int i = 0; i < 5; i++) drive(1'b1, 32'h0, 1'b1, 1'b0, acc);
      drain();
      chk("sat_cnt2", 64'(err_count2), 64'd3);
      chk("sat_cnt8", 64'(err_count), 64'd5);
      drive(1'b1, 32'h0, 1'b1, 1'b0, acc);
      drive(1'b0, 32'h0, 1'b0, 1'b0, acc);
      chk("clr_pre_vld", 64'(out_valid), 64'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b1, acc);
      chk("clr_prio8", 64'(err_count), 64'd0);
      chk("clr_prio2", 64'(err_count2), 64'd0);

      // Reset with both stages full.
      drive(1'b1, 32'h0, 1'b1, 1'b0, acc);
      drain();
      for (int i = 0; i < 3; i++) drive(1'b1, 32'h0000_0010 << i, 1'b0, 1'b0, acc);
      chk("mr_full", 64'(in_ready), 64'd0);
      reset = 1'b1;
      drive(1'b0, 32'h0, 1'b0, 1'b0, acc);
      chk("mr_out_valid", 64'(out_valid), 64'd0);
      chk("mr_err_count", 64'(err_count), 64'd0);
      reset = 1'b0;
      #1;
      chk("mr_in_ready", 64'(in_ready), 64'd1);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 32'h0, 1'b1, 1'b0, acc);
         chk("mr_no_stale", 64'(out_valid), 64'd0);
      end

      // Randomised traffic.
      for (int i = 0; i < 3000; i++) begin
         drive(1'($urandom_range(0, 1)), rnd_vec(), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 60) == 0), acc);
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/onehot_encoder_pipe.md
Name: onehot_encoder_pipe

Overview:
Pipelined one-hot to binary encoder: the inverse of the team's gate-level N:2^N decoders, using the same bit-ordering convention. It recovers register indices from one-hot select vectors, such as register-file write enables and forwarding selects, for the hazard/forwarding unit. It flags any vector that is not exactly one-hot and keeps a saturating error count. Valid/ready handshake on both sides; 2-cycle latency.

Parameters:
WIDTH, 32, width of one-hot input; power of 2, minimum 4.
IDX_W, 5, output index width; must equal log2(WIDTH).
CNT_W, 8, width of saturating error counter.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  in_onehot is valid this cycle.
in_ready  output  1  stage 1 can accept this cycle.
in_onehot  input  WIDTH  one-hot select vector.
out_valid  output  1  out_idx/out_err valid.
out_ready  input  1  downstream accepts this cycle.
out_idx  output  IDX_W  encoded index.
out_err  output  1  input was not exactly one-hot.
err_clr  input  1  clears err_count.
err_count  output  CNT_W  saturating count of accepted errored vectors.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Index mapping, identical to the team decoders (MSB-first):
  - in_onehot[WIDTH-1] encodes to index 0.
  - in_onehot[j] encodes to index WIDTH-1-j.
  - in_onehot[0] encodes to WIDTH-1.
  - Example, WIDTH=4: 4'b1000 -> 0, 4'b0001 -> 3.
- Priority on multi-hot input: encode the most significant set bit (lowest index). Zero input: out_idx=0.
- out_err=1 when popcount(in_onehot) != 1; otherwise 0.
- Stage 1 (s1): input split into 4 groups of WIDTH/4 bits.
  - Register per-group: any-set flag, local index of the highest set bit, multi-hot flag.
  - Also register s1_valid.
- Stage 2 (s2) combines the group results:
  - Group select = highest-priority group with any-set.
  - out_idx = {group, local}.
  - err = (no group set) OR (more than one group set) OR (selected group multi-hot).
  - Registers out_valid, out_idx, out_err.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - s2 loads when !out_valid || out_ready.
  - s1 loads when !s1_valid || s2 loads.
  - in_ready = !s1_valid || s2 loads. This is combinational from out_ready; no skid buffer.
- Stalls:
  - While out_valid && !out_ready, out_idx and out_err hold stable.
  - s1 holds its contents.
  - in_ready is 0 when s1 is full.
- Throughput: 1 vector per cycle when out_ready=1. Latency: accepted at edge N, out_valid=1 after edge N+1.
- err_count:
  - Increments by 1 on each output transfer with out_err=1.
  - Saturates at 2^CNT_W-1; no wrap.
  - err_clr has priority: if err_clr and an errored transfer occur in the same cycle, the result is 0.
- Reset, including mid-operation:
  - Next edge: s1_valid=0, out_valid=0, out_idx=0, out_err=0, err_count=0.
  - In-flight vectors are discarded.
  - in_ready=1 in the cycle after reset deasserts.
- Data and error registers are not updated by bubbles. When s2 loads an empty s1: out_valid=0 and out_idx holds its prior value.

Test Plan:
- Reset then stream (WIDTH=32): 32'h8000_0000, 32'h0000_0001, 32'h0001_0000 back-to-back with out_ready=1. Required: out_idx 0, 31, 15 on consecutive cycles, each 2 cycles after acceptance; out_err=0 throughout.
- Error cases: 32'h0 -> idx 0, err 1. 32'h0000_0003 -> idx 30, err 1. 32'h8000_0001 (cross-group) -> idx 0, err 1. Afterwards err_count=3.
- Backpressure: hold out_ready=0 for 5 cycles while feeding 4 vectors. Required: only 2 accepted; in_ready=0 after that; out_idx stable. On release, all outputs arrive in order with no loss or duplication.
- Saturation with CNT_W=2: 5 errored vectors -> err_count reaches 3 and holds. Then err_clr concurrent with an errored transfer -> 0.
- Reset mid-stream: assert reset with both stages full. Required: out_valid=0 and err_count=0 next cycle; no stale output after reset deasserts.
- Randomised one-hot input vs reference model (index = WIDTH-1-position), with random in_valid/out_ready. Required: every output matches in order.
